mult_div_unit: RTL and testbench

- Iterative signed multiply/divide unit for the multicycle datapath.
- Consumes the same A/B operand registers that drive the ALU source muxes.
- Produces HI/LO results for mult, div, mfhi and mflo.
- The control FSM starts it with a one-cycle pulse and waits on busy/done. It sits alongside the ALU stage, on the datapath the operand muxes feed.

---
 rtl/mult_div_unit.sv | 185 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit producing HI/LO.
// Multiply is radix-2 Booth; divide is restoring division on magnitudes,
// truncating toward zero. Each normal operation takes WIDTH iteration cycles
// plus one FIN cycle. A divide by zero finishes at once and leaves hi/lo untouched.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MULT, DIV, FIN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Multiply: sign-extended multiplicand. Divide: zero-extended |b|.
  logic [WIDTH:0]   opnd_q, opnd_d;
  // Multiply: P_hi. Divide: partial remainder.
  logic [WIDTH:0]   acc_q, acc_d;
  // Multiply: P_lo. Divide: dividend shifting out / quotient shifting in.
  logic [WIDTH-1:0] low_q, low_d;
  logic             qm1_q, qm1_d;
  logic             qneg_q, qneg_d;     // quotient must be negated
  logic             rneg_q, rneg_d;     // remainder takes the sign of a
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Datapath helpers
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   booth_acc;
  logic [WIDTH-1:0] booth_low;
  logic [WIDTH:0]   div_shift, div_trial, div_acc;
  logic [WIDTH-1:0] div_low;
  logic [WIDTH-1:0] quo_fin, rem_fin;

  // Operand magnitudes; INT_MIN maps to 2^(WIDTH-1), which is correct as unsigned.
  always_comb begin
    abs_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    abs_b = b[WIDTH-1] ? (~b + 1'b1) : b;
  end

  // One Booth step: add/subtract/skip, then arithmetic shift of {P_hi,P_lo,q-1}.
  always_comb begin
    booth_sum = acc_q;
    case ({low_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + opnd_q;
      2'b10:   booth_sum = acc_q - opnd_q;
      default: booth_sum = acc_q;
    endcase
    booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    booth_low = {booth_sum[0], low_q[WIDTH-1:1]};
  end

  // One restoring-division step plus the signed fix-up used on the last step.
  always_comb begin
    div_shift = {acc_q[WIDTH-1:0], low_q[WIDTH-1]};
    div_trial = div_shift - opnd_q;
    if (!div_trial[WIDTH]) begin
      div_acc = div_trial;
      div_low = {low_q[WIDTH-2:0], 1'b1};
    end else begin
      div_acc = div_shift;
      div_low = {low_q[WIDTH-2:0], 1'b0};
    end
    quo_fin = qneg_q ? (~div_low + 1'b1) : div_low;
    rem_fin = rneg_q ? (~div_acc[WIDTH-1:0] + 1'b1) : div_acc[WIDTH-1:0];
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    low_d   = low_q;
    qm1_d   = qm1_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    div0_d  = div0_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d  = CW'(WIDTH);
          qm1_d  = 1'b0;
          acc_d  = '0;
          qneg_d = a[WIDTH-1] ^ b[WIDTH-1];
          rneg_d = a[WIDTH-1];
          div0_d = 1'b0;
          if (!op) begin
            opnd_d  = {a[WIDTH-1], a};
            low_d   = b;
            state_d = MULT;
          end else if (b != '0) begin
            opnd_d  = {1'b0, abs_b};
            low_d   = abs_a;
            state_d = DIV;
          end else begin
            div0_d  = 1'b1;
            state_d = FIN;
          end
        end
      end
      MULT: begin
        acc_d = booth_acc;
        low_d = booth_low;
        qm1_d = low_q[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          hi_d    = booth_acc[WIDTH-1:0];
          lo_d    = booth_low;
          state_d = FIN;
        end
      end
      DIV: begin
        acc_d = div_acc;
        low_d = div_low;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          hi_d    = rem_fin;
          lo_d    = quo_fin;
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset that also aborts an operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      low_q   <= '0;
      qm1_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      low_q   <= low_d;
      qm1_q   <= qm1_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      div0_q  <= div0_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Status outputs are decoded straight from the state register.
  always_comb begin
    busy     = (state_q == MULT) || (state_q == DIV);
    done     = (state_q == FIN);
    div_zero = (state_q == FIN) && div0_q;
    hi       = hi_q;
    lo       = lo_q;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected results,
// a negedge monitor pops and checks them whenever done pulses.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int busy_cnt = 0;
  int txn   = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          busy_n;
    int          t0;
  } exp_t;

  exp_t exp_q[$];

  mult_div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  // Monitor: counts busy cycles and checks each completed operation.
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 want no result pending");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          txn++;
          $display("txn %0d: hi=%h lo=%h div_zero=%b latency=%0d busy_cycles=%0d",
                   txn, hi, lo, div_zero, cyc - e.t0, busy_cnt);
          check("hi", hi, e.hi);
          check("lo", lo, e.lo);
          check("div_zero", {31'b0, div_zero}, {31'b0, e.dz});
          check("latency", 32'(cyc - e.t0), 32'(e.lat));
          check("busy_cycles", 32'(busy_cnt), 32'(e.busy_n));
        end
        busy_cnt = 0;
      end
    end
  end

  // Drive start for one cycle; called just after a falling edge.
  task automatic pulse(input logic o, input logic [31:0] ai, input logic [31:0] bi);
    start = 1'b1;
    op    = o;
    a     = ai;
    b     = bi;
    @(negedge clk); #1;
    start = 1'b0;
    a     = '0;
    b     = '0;
  endtask

  task automatic issue(input logic o, input logic [31:0] ai, input logic [31:0] bi,
                       input logic [31:0] eh, input logic [31:0] el, input logic edz);
    exp_t e;
    e.hi     = eh;
    e.lo     = el;
    e.dz     = edz;
    e.lat    = edz ? 1 : 33;
    e.busy_n = edz ? 0 : 32;
    e.t0     = cyc;
    exp_q.push_back(e);
    pulse(o, ai, bi);
  endtask

  // Wait (bounded) for the scoreboard to drain, then one idle cycle.
  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk); #1;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout: got %0d results pending want 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_div_zero", {31'b0, div_zero}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    #1 reset = 1'b0;
    @(negedge clk); #1;

    // Multiplies
    issue(1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0); drain();
    issue(1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0); drain();
    issue(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0); drain();
    issue(1'b0, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0); drain();
    issue(1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd0, 32'd30, 1'b0); drain();

    // Divides, truncation toward zero
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0); drain();
    issue(1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0); drain();
    issue(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0); drain();
    issue(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0); drain();
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0); drain();

    // Divide by zero leaves the previous result in place
    issue(1'b1, 32'd5, 32'd2, 32'd1, 32'd2, 1'b0); drain();
    issue(1'b1, 32'd5, 32'd0, 32'd1, 32'd2, 1'b1); drain();

    // A second start mid-multiply is ignored
    issue(1'b0, 32'd100, 32'd200, 32'd0, 32'd20000, 1'b0);
    repeat (9) begin @(negedge clk); #1; end
    pulse(1'b1, 32'd9, 32'd3);
    drain();

    // Reset in the middle of a divide discards it
    pulse(1'b1, 32'd1000, 32'd3);
    repeat (14) begin @(negedge clk); #1; end
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    #1 reset = 1'b0;
    @(negedge clk); #1;
    issue(1'b0, 32'd6, 32'd6, 32'd0, 32'd36, 1'b0); drain();

    // No stray result after the last operation
    repeat (40) begin @(negedge clk); #1; end
    check("pending_left", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got simulation still running want finished");
    $fatal(1, "global timeout");
  end

endmodule
